input_debounce: RTL and testbench
=================================

Name: input_debounce

Overview:
- Conditions the raw asynchronous board inputs (slide switches, push-buttons) before they reach the demo system, the PWM pulse-width input and the LED logic.
- Per channel: multi-stage synchroniser, then a consecutive-cycle stability counter.
- Outputs a clean debounced level plus single-cycle rise and fall pulses per channel.
- Sits directly upstream of the board-level logic that consumes SW/BTN.

Parameters:
- NumInputs, 8, number of independent channels (4 SW + 4 BTN).
- DebounceCycles, 50000, consecutive stable synchronised cycles required to accept a new level; legal range 1..2^20.
- SyncStages, 2, synchroniser flop depth; legal range 2..4.
- ResetValue, '0 (NumInputs bits), reset value of synchroniser flops and level_o per channel.

Ports:
- clk_sys_i  input  1  system clock
- rst_sys_ni  input  1  synchronous active-low reset, sampled on posedge clk_sys_i
- raw_i  input  NumInputs  asynchronous raw pad inputs
- level_o  output  NumInputs  debounced level, registered
- rise_o  output  NumInputs  one-cycle pulse, 0->1 acceptance on level_o, registered
- fall_o  output  NumInputs  one-cycle pulse, 1->0 acceptance on level_o, registered

Behaviour:
- Reset: synchronous. While rst_sys_ni=0 at a clock edge:
  - sync flops and level_o <= ResetValue.
  - counters <= 0.
  - rise_o, fall_o <= 0.
  - No pulses are generated on reset release, even if raw_i differs from ResetValue. A differing input is accepted only after a full debounce period.
- Synchroniser: raw_i passes through SyncStages flops. s_i is the last stage output. Latency raw->s_i is SyncStages cycles.
- Per channel, each cycle, in priority order:
  - s_i == level_o: cnt <= 0; no pulse.
  - s_i != level_o and cnt == DebounceCycles-1: level_o <= s_i; cnt <= 0; rise_o <= s_i; fall_o <= ~s_i.
  - otherwise: cnt <= cnt+1; no pulse.
  - rise_o and fall_o are 0 in every cycle not covered by the acceptance case.
- Net latency: a clean input step changes level_o exactly SyncStages+DebounceCycles cycles after the first sampling edge. rise_o/fall_o assert in that same cycle for exactly one cycle.
- Glitch rejection: any return of s_i to level_o before the count completes clears cnt. Pulses narrower than DebounceCycles cycles never reach level_o.
- Counter width: $clog2(DebounceCycles+1) bits, compared with ==. The counter can never exceed DebounceCycles-1, so there is no wrap.
- DebounceCycles=1: acceptance on the first differing cycle. Latency = SyncStages+1.
- Channels are fully independent. Simultaneous acceptance on several channels produces simultaneous pulses.
- rise_o and fall_o are never both 1 on the same channel. A pulse implies level_o changed in that same cycle.
- Reset asserted mid-count: count is discarded, level_o returns to ResetValue, no pulse.
- Elaboration errors:
  - DebounceCycles < 1 is a fatal error.
  - SyncStages < 2 is a fatal error.

Decomposition:
- No shared package. All sizing is parameter-derived. Counter width is a localparam inside the channel.
- One sub-module, debounce_chan: a single channel holding the synchroniser, counter, level and pulse registers.
- input_debounce instantiates NumInputs copies in a generate loop.

Test Plan (DebounceCycles=4, SyncStages=2, NumInputs=8, ResetValue=0 unless stated):
- Reset/hold: hold rst_sys_ni=0 for 3 cycles with raw_i=8'hFF, then release. Required: level_o=0x00 and no pulses until 2+4=6 cycles after release; then level_o=0xFF and rise_o=0xFF for exactly one cycle; fall_o stays 0.
- Clean step: raw_i[3] 0->1 at cycle T. Required: level_o[3]=1 and rise_o[3]=1 at T+6; rise_o[3]=0 at T+7; other bits unchanged.
- Glitch reject: raw_i[0] high for 3 cycles, then low. Required: level_o[0] stays 0 and rise_o[0] never asserts. Then hold high for 4+ cycles. Required: accepted at first-high+6.
- Bounce: raw_i[5] toggles 1,0,1,0,1 with 2-cycle periods, then stays 1. Required: exactly one rise_o[5] pulse, 6 cycles after the final 0->1 edge; no fall_o[5].
- Falling/simultaneous: with level_o=0xFF, drive raw_i=0x0F in one cycle. Required: fall_o=0xF0 one cycle, level_o=0x0F, rise_o=0x00.
- Reset mid-count plus DebounceCycles=1 variant:
  - Assert reset 2 cycles into a count. Required: level_o=0, no pulse.
  - Separate build with DebounceCycles=1. Required: step latency exactly 3 cycles.

Source files
------------

// File: rtl/debounce_chan.sv
// ============================================================================
// Module   : debounce_chan
// Purpose  : One input channel: synchroniser, stability counter, level and
//            single-cycle rise/fall pulse registers.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module debounce_chan #(
  parameter int   DebounceCycles = 50000,
  parameter int   SyncStages     = 2,
  parameter logic ResetValue     = 1'b0
) (
  input  logic clk_sys_i,
  input  logic rst_sys_ni,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int              CNT_W    = $clog2(DebounceCycles + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DebounceCycles - 1);

  if (DebounceCycles < 1) begin : g_bad_cycles
    $fatal(1, "debounce_chan: DebounceCycles must be at least 1");
  end
  if (SyncStages < 2) begin : g_bad_stages
    $fatal(1, "debounce_chan: SyncStages must be at least 2");
  end

  logic [SyncStages-1:0] sync_ff;
  logic                  synced;
  logic [CNT_W-1:0]      cnt;

  assign synced = sync_ff[SyncStages-1];

  always_ff @(posedge clk_sys_i) begin
    if (!rst_sys_ni) begin
      sync_ff <= {SyncStages{ResetValue}};
      level_o <= ResetValue;
      cnt     <= '0;
      rise_o  <= 1'b0;
      fall_o  <= 1'b0;
    end else begin
      sync_ff <= {sync_ff[SyncStages-2:0], raw_i};
      rise_o  <= 1'b0;
      fall_o  <= 1'b0;
      // Any cycle matching the current level restarts the stability window.
      if (synced == level_o) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level_o <= synced;
        cnt     <= '0;
        rise_o  <= synced;
        fall_o  <= ~synced;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/input_debounce.sv
// ============================================================================
// Module   : input_debounce
// Purpose  : Debounces NumInputs raw board inputs into clean levels plus
//            one-cycle rise/fall pulses, one independent channel per bit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module input_debounce #(
  parameter int                  NumInputs      = 8,
  parameter int                  DebounceCycles = 50000,
  parameter int                  SyncStages     = 2,
  parameter logic [NumInputs-1:0] ResetValue    = '0
) (
  input  logic                 clk_sys_i,
  input  logic                 rst_sys_ni,
  input  logic [NumInputs-1:0] raw_i,
  output logic [NumInputs-1:0] level_o,
  output logic [NumInputs-1:0] rise_o,
  output logic [NumInputs-1:0] fall_o
);

  if (DebounceCycles < 1) begin : g_bad_cycles
    $fatal(1, "input_debounce: DebounceCycles must be at least 1");
  end
  if (SyncStages < 2) begin : g_bad_stages
    $fatal(1, "input_debounce: SyncStages must be at least 2");
  end

  for (genvar i = 0; i < NumInputs; i++) begin : g_chan
    debounce_chan #(
      .DebounceCycles (DebounceCycles),
      .SyncStages     (SyncStages),
      .ResetValue     (ResetValue[i])
    ) u_chan (
      .clk_sys_i  (clk_sys_i),
      .rst_sys_ni (rst_sys_ni),
      .raw_i      (raw_i[i]),
      .level_o    (level_o[i]),
      .rise_o     (rise_o[i]),
      .fall_o     (fall_o[i])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_input_debounce.sv
// ============================================================================
// Module   : tb_input_debounce
// Purpose  : Self-checking bench for input_debounce (D=4 and D=1 builds).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_input_debounce;

  localparam int S   = 2;
  localparam int D_A = 4;
  localparam int D_B = 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] raw_a, raw_b;
  logic [7:0] level_a, rise_a, fall_a;
  logic [7:0] level_b, rise_b, fall_b;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  input_debounce #(
    .NumInputs(8), .DebounceCycles(D_A), .SyncStages(S), .ResetValue(8'h00)
  ) dut (
    .clk_sys_i(clk), .rst_sys_ni(rst_n), .raw_i(raw_a),
    .level_o(level_a), .rise_o(rise_a), .fall_o(fall_a)
  );

  input_debounce #(
    .NumInputs(8), .DebounceCycles(D_B), .SyncStages(S), .ResetValue(8'h00)
  ) dut_fast (
    .clk_sys_i(clk), .rst_sys_ni(rst_n), .raw_i(raw_b),
    .level_o(level_b), .rise_o(rise_b), .fall_o(fall_b)
  );

  // Reference: a delay line of S samples, then a level that flips once the
  // delayed input has disagreed with it for D consecutive cycles.
  logic [7:0] m_dly[2][S];
  logic [7:0] m_level[2], m_rise[2], m_fall[2];
  int         m_run[2][8];
  logic [7:0] m_raw;
  int         m_d;

  always @(posedge clk) begin
    for (int c = 0; c < 2; c++) begin
      m_raw = (c == 0) ? raw_a : raw_b;
      m_d   = (c == 0) ? D_A : D_B;
      if (!rst_n) begin
        for (int k = 0; k < S; k++) m_dly[c][k] = 8'h00;
        m_level[c] = 8'h00;
        m_rise[c]  = 8'h00;
        m_fall[c]  = 8'h00;
        for (int b = 0; b < 8; b++) m_run[c][b] = 0;
      end else begin
        m_rise[c] = 8'h00;
        m_fall[c] = 8'h00;
        for (int b = 0; b < 8; b++) begin
          if (m_dly[c][S-1][b] == m_level[c][b]) begin
            m_run[c][b] = 0;
          end else begin
            m_run[c][b] = m_run[c][b] + 1;
            if (m_run[c][b] == m_d) begin
              m_level[c][b] = m_dly[c][S-1][b];
              if (m_level[c][b]) m_rise[c][b] = 1'b1;
              else               m_fall[c][b] = 1'b1;
              m_run[c][b] = 0;
            end
          end
        end
        for (int k = S - 1; k > 0; k--) m_dly[c][k] = m_dly[c][k-1];
        m_dly[c][0] = m_raw;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] el, er;
    rst_n = 1'b0;
    raw_a = 8'hFF;
    raw_b = 8'hFF;
    repeat (3) tick();
    checks++;
    if ({level_a, rise_a, fall_a} !== 24'h0) begin
      failures++;
      $display("FAIL reset_state: got lvl=%h rise=%h fall=%h want 00/00/00", level_a, rise_a, fall_a);
    end
    rst_n = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      el = (i >= 6) ? 8'hFF : 8'h00;
      er = (i == 6) ? 8'hFF : 8'h00;
      checks++;
      if ({level_a, rise_a, fall_a} !== {el, er, 8'h00}) begin
        failures++;
        $display("FAIL reset_release t=%0d: got lvl=%h rise=%h fall=%h want %h/%h/00", i, level_a, rise_a, fall_a, el, er);
      end
    end
  endtask

  task automatic test_clean_step();
    logic [7:0] el, er;
    raw_a = 8'h00;
    repeat (8) tick();
    raw_a[3] = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      el = (i >= 6) ? 8'h08 : 8'h00;
      er = (i == 6) ? 8'h08 : 8'h00;
      checks++;
      if ({level_a, rise_a, fall_a} !== {el, er, 8'h00}) begin
        failures++;
        $display("FAIL clean_step t=%0d: got lvl=%h rise=%h fall=%h want %h/%h/00", i, level_a, rise_a, fall_a, el, er);
      end
    end
  endtask

  task automatic test_glitch();
    raw_a[0] = 1'b1;
    for (int i = 1; i <= 11; i++) begin
      tick();
      if (i == 3) raw_a[0] = 1'b0;
      checks++;
      if (level_a[0] !== 1'b0 || rise_a[0] !== 1'b0) begin
        failures++;
        $display("FAIL glitch_reject t=%0d: got lvl0=%b rise0=%b want 0/0", i, level_a[0], rise_a[0]);
      end
    end
    raw_a[0] = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      checks++;
      if (level_a[0] !== (i >= 6) || rise_a[0] !== (i == 6)) begin
        failures++;
        $display("FAIL glitch_accept t=%0d: got lvl0=%b rise0=%b want %b/%b", i, level_a[0], rise_a[0], i >= 6, i == 6);
      end
    end
  endtask

  task automatic test_bounce();
    logic v;
    for (int seg = 0; seg < 4; seg++) begin
      v = (seg % 2 == 0);
      raw_a[5] = v;
      repeat (2) begin
        tick();
        checks++;
        if (level_a[5] !== 1'b0 || rise_a[5] !== 1'b0 || fall_a[5] !== 1'b0) begin
          failures++;
          $display("FAIL bounce_hold seg=%0d: got lvl5=%b rise5=%b fall5=%b want 0/0/0", seg, level_a[5], rise_a[5], fall_a[5]);
        end
      end
    end
    raw_a[5] = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      checks++;
      if (level_a[5] !== (i >= 6) || rise_a[5] !== (i == 6) || fall_a[5] !== 1'b0) begin
        failures++;
        $display("FAIL bounce_settle t=%0d: got lvl5=%b rise5=%b fall5=%b want %b/%b/0", i, level_a[5], rise_a[5], fall_a[5], i >= 6, i == 6);
      end
    end
  endtask

  task automatic test_simultaneous_fall();
    logic [7:0] el, ef;
    raw_a = 8'hFF;
    repeat (8) tick();
    checks++;
    if (level_a !== 8'hFF) begin
      failures++;
      $display("FAIL all_high: got lvl=%h want ff", level_a);
    end
    raw_a = 8'h0F;
    for (int i = 1; i <= 8; i++) begin
      tick();
      el = (i >= 6) ? 8'h0F : 8'hFF;
      ef = (i == 6) ? 8'hF0 : 8'h00;
      checks++;
      if ({level_a, rise_a, fall_a} !== {el, 8'h00, ef}) begin
        failures++;
        $display("FAIL simul_fall t=%0d: got lvl=%h rise=%h fall=%h want %h/00/%h", i, level_a, rise_a, fall_a, el, ef);
      end
    end
  endtask

  task automatic test_reset_mid_count();
    raw_a = 8'hFF;
    repeat (4) tick();
    rst_n = 1'b0;
    tick();
    checks++;
    if ({level_a, rise_a, fall_a} !== 24'h0) begin
      failures++;
      $display("FAIL reset_mid: got lvl=%h rise=%h fall=%h want 00/00/00", level_a, rise_a, fall_a);
    end
    rst_n = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      tick();
      checks++;
      if (rise_a !== ((i == 6) ? 8'hFF : 8'h00) || fall_a !== 8'h00) begin
        failures++;
        $display("FAIL reset_mid_after t=%0d: got rise=%h fall=%h", i, rise_a, fall_a);
      end
    end
  endtask

  task automatic test_fast_latency();
    raw_b = 8'hFF;
    repeat (4) tick();
    raw_b[2] = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      checks++;
      if (level_b[2] !== (i < 3) || fall_b[2] !== (i == 3) || rise_b[2] !== 1'b0) begin
        failures++;
        $display("FAIL fast_fall t=%0d: got lvl2=%b fall2=%b rise2=%b want %b/%b/0", i, level_b[2], fall_b[2], rise_b[2], i < 3, i == 3);
      end
    end
    raw_b[2] = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      checks++;
      if (level_b[2] !== (i >= 3) || rise_b[2] !== (i == 3)) begin
        failures++;
        $display("FAIL fast_rise t=%0d: got lvl2=%b rise2=%b want %b/%b", i, level_b[2], rise_b[2], i >= 3, i == 3);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < 8; b++) begin
        if ($urandom_range(4, 0) == 0) raw_a[b] = ~raw_a[b];
        if ($urandom_range(2, 0) == 0) raw_b[b] = ~raw_b[b];
      end
      rst_n = ($urandom_range(499, 0) != 0);
      tick();
      checks++;
      if ({level_a, rise_a, fall_a} !== {m_level[0], m_rise[0], m_fall[0]}) begin
        failures++;
        $display("FAIL random_a i=%0d: got %h/%h/%h want %h/%h/%h", i, level_a, rise_a, fall_a, m_level[0], m_rise[0], m_fall[0]);
      end
      checks++;
      if ({level_b, rise_b, fall_b} !== {m_level[1], m_rise[1], m_fall[1]}) begin
        failures++;
        $display("FAIL random_b i=%0d: got %h/%h/%h want %h/%h/%h", i, level_b, rise_b, fall_b, m_level[1], m_rise[1], m_fall[1]);
      end
      checks++;
      if ((rise_a & fall_a) !== 8'h00 || (rise_b & fall_b) !== 8'h00) begin
        failures++;
        $display("FAIL random_excl i=%0d: got a=%h b=%h want 00", i, rise_a & fall_a, rise_b & fall_b);
      end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    raw_a = 8'h00;
    raw_b = 8'h00;
    test_reset();
    test_clean_step();
    test_glitch();
    test_bounce();
    test_simultaneous_fall();
    test_reset_mid_count();
    test_fast_latency();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
